kf8237_bus_initiator: RTL and testbench
=======================================

Name: kf8237_bus_initiator

Overview:
CPU-side bus master that generates I/O read and write cycles toward the KF8237 register interface. It converts a simple request/response handshake into timed chip-select, read-strobe, write-strobe, address and data sequences. It is used by the init/BIOS-assist logic and test harnesses to program and read back DMA channel registers. It optionally expands 16-bit address/count accesses into byte-pointer-correct byte pairs.

Parameters:
SETUP_CYCLES, 1, cycles with CS and address valid before the strobe asserts (min 1)
STROBE_CYCLES, 2, cycles the read or write strobe is held low (min 1)
HOLD_CYCLES, 1, cycles CS and address are held after the strobe deasserts (min 1; the target detects the write on strobe release with CS still low and a one-clock-delayed address)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  initiator can accept a request
req_write  in  1  1 = write, 0 = read
req_word  in  1  1 = 16-bit access (low byte, then high byte, same address)
req_address  in  4  target register address
req_data  in  16  write data; byte access uses [7:0]
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  16  read data; 0 for writes
bus_hold  in  1  bus owned by DMA; defer the start of any access
busy  out  1  request in progress
chip_select_n  out  1  target chip select, active-low
io_read_n  out  1  read strobe, active-low
io_write_n  out  1  write strobe, active-low
address_out  out  4  target address
data_bus_out  out  8  write data byte
data_bus_in  in  8  read data byte from target

Behaviour:
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_data=0, chip_select_n=1, io_read_n=1, io_write_n=1, address_out=0, data_bus_out=0. All outputs are registered.
- Request acceptance: a request is accepted on an edge where req_valid & req_ready. req_address, req_data, req_write and req_word are captured. req_ready=0 and busy=1 from the next cycle until the cycle after rsp_valid.
- Access list per request:
  - Byte request: one access.
  - Word request: low access (addr, data[7:0]), then high access (addr, data[15:8]).
  - With the optional feature enabled, a word request is preceded by a write of 0x00 to address 0xC (clear byte pointer).
- State machine: IDLE -> WAIT -> SETUP -> STROBE -> HOLD -> (WAIT for the next access | DONE) -> IDLE.
  - WAIT: all bus outputs are inactive (CS, IOR, IOW = 1). Leaves for SETUP on the first edge where bus_hold=0; if bus_hold=0 at entry, WAIT lasts 0 cycles, i.e. SETUP follows the accept edge directly.
  - SETUP: CS=0, address_out valid, data_bus_out valid on writes, both strobes at 1. Lasts SETUP_CYCLES.
  - STROBE: io_write_n=0 (write) or io_read_n=0 (read). Lasts STROBE_CYCLES. Read data is sampled on the edge that ends the last STROBE cycle.
  - HOLD: strobes at 1; CS, address and data are held. Lasts HOLD_CYCLES.
  - DONE: rsp_valid=1 for exactly one cycle with rsp_data; then IDLE.
- Cycle counts: one access = SETUP+STROBE+HOLD cycles (defaults: 4). Accesses within a request are separated by 1 inactive WAIT cycle when bus_hold=0.
- bus_hold is sampled only in WAIT. Once an access has started it always completes, regardless of bus_hold.
- rsp_data: byte read = {8'h00, byte}; word read = {high, low}; write = 0.
- Reset mid-operation: on the reset edge all outputs return to reset values, the in-flight request is discarded, and no rsp_valid is generated.
- Counter width: $clog2 of the largest parameter + 1. Counters never wrap; each reloads on state entry.

Optional Feature:
KF8237_AUTO_CLEAR_BYTE_POINTER_EN
- Defined: every word request first performs a write access of 0x00 to address 0xC, then the low and high accesses (3 accesses total).
- Undefined: a word request performs only the low and high accesses. Software is responsible for the byte pointer state.

Test Plan:
- Byte write, defaults, addr=0x8, data=0x14, accepted at edge N -> CS=0 cycles N+1..N+4; IOW=0 cycles N+2..N+3; address_out=0x8, data_bus_out=0x14 throughout; rsp_valid pulse at N+5 with rsp_data=0; req_ready=1 at N+6.
- Word write, addr=0x0, data=0x1234, feature on -> accesses (0xC,0x00), (0x0,0x34), (0x0,0x12) in order, each with 1 inactive cycle between; exactly 3 IOW pulses; single rsp_valid. With the feature off -> only 2 accesses.
- Word read, addr=0x1, target drives 0xCD on the first access and 0xAB on the second -> rsp_data=0xABCD; io_write_n stays 1 throughout.
- bus_hold=1 for 5 cycles starting at the accept edge -> CS stays 1 for those 5 cycles, the access begins on the first cycle after release. bus_hold asserted during STROBE -> access completes unchanged.
- Reset asserted during STROBE of a read -> next cycle: CS, IOR, IOW all 1, busy=0, req_ready=1, no rsp_valid ever appears.
- Back-to-back: req_valid held high with 2 requests -> the second is accepted only in the cycle after the first rsp_valid; no overlapping CS.

Source files
------------

// File: rtl/kf8237_bus_initiator.sv
// CPU-side bus master issuing timed I/O read/write cycles to the KF8237 register file.
// Define KF8237_AUTO_CLEAR_BYTE_POINTER_EN to prefix word accesses with a byte-pointer clear.
module kf8237_bus_initiator #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_word_i,
    input  logic [3:0]  req_address_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    input  logic        bus_hold_i,
    output logic        busy_o,
    output logic        chip_select_n_o,
    output logic        io_read_n_o,
    output logic        io_write_n_o,
    output logic [3:0]  address_out_o,
    output logic [7:0]  data_bus_out_o,
    input  logic [7:0]  data_bus_in_i
);

    localparam int unsigned MaxSs  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned MaxCyc = (MaxSs > HOLD_CYCLES) ? MaxSs : HOLD_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    typedef enum logic [2:0] {StIdle, StWait, StSetup, StStrobe, StHold, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              write_q, write_d;
    logic              word_q, word_d;
    logic [15:0]       rd_q, rd_d;

    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              cs_n_q, cs_n_d;
    logic              ior_n_q, ior_n_d;
    logic              iow_n_q, iow_n_d;
    logic [3:0]        aout_q, aout_d;
    logic [7:0]        dout_q, dout_d;

    logic [12:0]       info_q, info_d;
    logic              active_d;

    function automatic logic [1:0] last_idx(input logic word);
`ifdef KF8237_AUTO_CLEAR_BYTE_POINTER_EN
        return word ? 2'd2 : 2'd0;
`else
        return word ? 2'd1 : 2'd0;
`endif
    endfunction

    // Access descriptor {write, address, data byte} for access number idx of a request.
    function automatic logic [12:0] access_info(input logic [1:0] idx, input logic [3:0] addr,
                                                input logic [15:0] data, input logic wr,
                                                input logic word);
`ifdef KF8237_AUTO_CLEAR_BYTE_POINTER_EN
        if (word && idx == 2'd0) return {1'b1, 4'hC, 8'h00};
`endif
        if (word && idx == last_idx(word)) return {wr, addr, data[15:8]};
        return {wr, addr, data[7:0]};
    endfunction

    assign info_q = access_info(idx_q, addr_q, data_q, write_q, word_q);
    assign info_d = access_info(idx_d, addr_d, data_d, write_d, word_d);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        word_d  = word_q;
        rd_d    = rd_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req_valid_i) begin
                    addr_d  = req_address_i;
                    data_d  = req_data_i;
                    write_d = req_write_i;
                    word_d  = req_word_i;
                    idx_d   = 2'd0;
                    rd_d    = 16'h0000;
                    state_d = bus_hold_i ? StWait : StSetup;
                end
            end
            StWait: begin
                cnt_d = '0;
                if (!bus_hold_i) state_d = StSetup;
            end
            StSetup: begin
                if (cnt_q == CntW'(SETUP_CYCLES - 1)) begin
                    state_d = StStrobe;
                    cnt_d   = '0;
                end
            end
            StStrobe: begin
                if (cnt_q == CntW'(STROBE_CYCLES - 1)) begin
                    if (!info_q[12]) begin
                        if (word_q && idx_q == last_idx(word_q)) rd_d[15:8] = data_bus_in_i;
                        else                                   rd_d[7:0]  = data_bus_in_i;
                    end
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (idx_q == last_idx(word_q)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StWait;
                    end
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered: derive them from the state being entered.
    always_comb begin
        active_d    = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
        req_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        rsp_valid_d = (state_d == StDone);
        rsp_data_d  = rsp_data_q;
        if (state_d == StDone) begin
            rsp_data_d = write_q ? 16'h0000 : (word_q ? rd_d : {8'h00, rd_d[7:0]});
        end
        cs_n_d  = !active_d;
        ior_n_d = !((state_d == StStrobe) && !info_d[12]);
        iow_n_d = !((state_d == StStrobe) && info_d[12]);
        aout_d  = active_d ? info_d[11:8] : aout_q;
        dout_d  = (active_d && info_d[12]) ? info_d[7:0] : dout_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            addr_q      <= 4'h0;
            data_q      <= 16'h0000;
            write_q     <= 1'b0;
            word_q      <= 1'b0;
            rd_q        <= 16'h0000;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            cs_n_q      <= 1'b1;
            ior_n_q     <= 1'b1;
            iow_n_q     <= 1'b1;
            aout_q      <= 4'h0;
            dout_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            word_q      <= word_d;
            rd_q        <= rd_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cs_n_q      <= cs_n_d;
            ior_n_q     <= ior_n_d;
            iow_n_q     <= iow_n_d;
            aout_q      <= aout_d;
            dout_q      <= dout_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign busy_o          = busy_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign chip_select_n_o = cs_n_q;
    assign io_read_n_o     = ior_n_q;
    assign io_write_n_o    = iow_n_q;
    assign address_out_o   = aout_q;
    assign data_bus_out_o  = dout_q;

endmodule

// File: tb/tb_kf8237_bus_initiator.sv
// Randomized and directed bench for kf8237_bus_initiator against a transaction-level model.
module tb_kf8237_bus_initiator;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;
    localparam int L = S + T + H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_word = 1'b0;
    logic [3:0]  req_address = 4'h0;
    logic [15:0] req_data = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        bus_hold = 1'b0;
    logic        busy;
    logic        cs_n;
    logic        ior_n;
    logic        iow_n;
    logic [3:0]  addr_out;
    logic [7:0]  dout;
    logic [7:0]  din = 8'h00;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit dir_mode = 1'b0;
    int rd_cnt = 0;
    logic prev_ior = 1'b1;

    kf8237_bus_initiator #(
        .SETUP_CYCLES (S),
        .STROBE_CYCLES(T),
        .HOLD_CYCLES  (H)
    ) dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_word_i     (req_word),
        .req_address_i  (req_address),
        .req_data_i     (req_data),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .bus_hold_i     (bus_hold),
        .busy_o         (busy),
        .chip_select_n_o(cs_n),
        .io_read_n_o    (ior_n),
        .io_write_n_o   (iow_n),
        .address_out_o  (addr_out),
        .data_bus_out_o (dout),
        .data_bus_in_i  (din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Target read data: directed mode returns 0xCD for the first read pulse, 0xAB afterwards.
    always @(negedge clk) begin
        if (!dir_mode) rd_cnt = 0;
        else if (!prev_ior && ior_n) rd_cnt = rd_cnt + 1;
        prev_ior = ior_n;
        din = dir_mode ? ((rd_cnt == 0) ? 8'hCD : 8'hAB) : 8'($urandom);
    end

    // Transaction-level model: a request expands to a list of accesses; each access spans
    // L bus cycles at positions 0..L-1, and m_pos = -1 means waiting for the bus.
    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic       wr;
    } acc_t;

    acc_t       mq[$];
    logic [7:0] mrd[$];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_word = 1'b0;
    bit         m_wr = 1'b0;
    int         m_pos = -1;
    logic [15:0] m_rsp = 16'h0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pos  = -1;
            mq.delete();
            mrd.delete();
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                mq.delete();
                mrd.delete();
                m_word = req_word;
                m_wr   = req_write;
                if (req_word) begin
`ifdef KF8237_AUTO_CLEAR_BYTE_POINTER_EN
                    mq.push_back('{a: 4'hC, d: 8'h00, wr: 1'b1});
`endif
                    mq.push_back('{a: req_address, d: req_data[7:0], wr: req_write});
                    mq.push_back('{a: req_address, d: req_data[15:8], wr: req_write});
                end else begin
                    mq.push_back('{a: req_address, d: req_data[7:0], wr: req_write});
                end
                m_busy = 1'b1;
                m_pos  = bus_hold ? -1 : 0;
            end
        end else if (m_pos < 0) begin
            if (!bus_hold) m_pos = 0;
        end else begin
            if (!mq[0].wr && m_pos == S + T - 1) mrd.push_back(din);
            m_pos++;
            if (m_pos == L) begin
                void'(mq.pop_front());
                m_pos = -1;
                if (mq.size() == 0) begin
                    m_done = 1'b1;
                    if (m_wr) m_rsp = 16'h0000;
                    else if (m_word) m_rsp = {mrd[1], mrd[0]};
                    else m_rsp = {8'h00, mrd[0]};
                end
            end
        end
    end

    always @(negedge clk) begin
        bit act;
        if (chk_en) begin
            act = m_busy && !m_done && (m_pos >= 0);
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            check("rsp_valid", 32'(rsp_valid), 32'(m_done));
            if (m_done) check("rsp_data", 32'(rsp_data), 32'(m_rsp));
            check("chip_select_n", 32'(cs_n), 32'(!act));
            check("io_read_n", 32'(ior_n),
                  32'(!(act && !mq[0].wr && m_pos >= S && m_pos < S + T)));
            check("io_write_n", 32'(iow_n),
                  32'(!(act && mq[0].wr && m_pos >= S && m_pos < S + T)));
            if (act) check("address_out", 32'(addr_out), 32'(mq[0].a));
            if (act && mq[0].wr) check("data_bus_out", 32'(dout), 32'(mq[0].d));
        end
    end

    logic [11:0] pulse_q[$];

    // Issue one request and follow it to its response; records (addr,data) of each write pulse.
    task automatic run_req(input logic wr, input logic word, input logic [3:0] a,
                           input logic [15:0] d, input bit hold_in_strobe,
                           output logic [15:0] rsp, output int n_iow, output int n_ior);
        bit   got = 1'b0;
        logic piow = 1'b1;
        logic pior = 1'b1;
        int   g = 0;
        n_iow = 0;
        n_ior = 0;
        rsp = 16'hxxxx;
        pulse_q.delete();
        @(negedge clk);
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_word = word;
        req_address = a;
        req_data = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            if (piow && !iow_n) begin
                n_iow++;
                pulse_q.push_back({addr_out, dout});
            end
            if (pior && !ior_n) n_ior++;
            piow = iow_n;
            pior = ior_n;
            if (hold_in_strobe && (!iow_n || !ior_n)) bus_hold = 1'b1;
            if (rsp_valid) begin
                got = 1'b1;
                rsp = rsp_data;
            end else begin
                @(negedge clk);
            end
        end
        bus_hold = 1'b0;
        check("response_seen", 32'(got), 32'd1);
    endtask

    logic [15:0] rsp;
    int          niow;
    int          nior;
    int          guard;
    int          nrsp;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_cs_n", 32'(cs_n), 32'd1);
        check("reset_ior_n", 32'(ior_n), 32'd1);
        check("reset_iow_n", 32'(iow_n), 32'd1);
        check("reset_address", 32'(addr_out), 32'd0);
        check("reset_data_out", 32'(dout), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Byte write timing pinned against literal cycle positions after the accept edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_word = 1'b0;
        req_address = 4'h8;
        req_data = 16'h0014;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            check($sformatf("bw_cs_n_c%0d", k), 32'(cs_n), (k <= 4) ? 32'd0 : 32'd1);
            check($sformatf("bw_iow_n_c%0d", k), 32'(iow_n), (k == 2 || k == 3) ? 32'd0 : 32'd1);
            check($sformatf("bw_rsp_valid_c%0d", k), 32'(rsp_valid), (k == 5) ? 32'd1 : 32'd0);
            check($sformatf("bw_req_ready_c%0d", k), 32'(req_ready), (k == 6) ? 32'd1 : 32'd0);
            if (k <= 4) begin
                check("bw_address", 32'(addr_out), 32'h8);
                check("bw_data", 32'(dout), 32'h14);
            end
            if (k == 5) check("bw_rsp_data", 32'(rsp_data), 32'h0);
        end

        // Word write sequence.
        run_req(1'b1, 1'b1, 4'h0, 16'h1234, 1'b0, rsp, niow, nior);
`ifdef KF8237_AUTO_CLEAR_BYTE_POINTER_EN
        check("ww_iow_pulses", 32'(niow), 32'd3);
        if (pulse_q.size() == 3) begin
            check("ww_acc0", 32'(pulse_q[0]), 32'hC00);
            check("ww_acc1", 32'(pulse_q[1]), 32'h034);
            check("ww_acc2", 32'(pulse_q[2]), 32'h012);
        end
`else
        check("ww_iow_pulses", 32'(niow), 32'd2);
        if (pulse_q.size() == 2) begin
            check("ww_acc0", 32'(pulse_q[0]), 32'h034);
            check("ww_acc1", 32'(pulse_q[1]), 32'h012);
        end
`endif
        check("ww_rsp_data", 32'(rsp), 32'h0);

        // Word read with target data 0xCD then 0xAB.
        dir_mode = 1'b1;
        run_req(1'b0, 1'b1, 4'h1, 16'h0000, 1'b0, rsp, niow, nior);
        check("wr_rsp_data", 32'(rsp), 32'hABCD);
        check("wr_iow_pulses", 32'(niow), 32'd0);
        check("wr_ior_pulses", 32'(nior), 32'd2);
        dir_mode = 1'b0;

        // Bus held for five edges starting at the accept edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_word = 1'b0;
        req_address = 4'h3;
        req_data = 16'h00A5;
        bus_hold = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            check($sformatf("hold_cs_n_c%0d", k), 32'(cs_n), (k < 6) ? 32'd1 : 32'd0);
            if (k == 5) bus_hold = 1'b0;
        end
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("hold_done", 32'(req_ready), 32'd1);

        // bus_hold raised mid-strobe must not disturb the access.
        run_req(1'b0, 1'b0, 4'h5, 16'h0000, 1'b1, rsp, niow, nior);
        check("hs_ior_pulses", 32'(nior), 32'd1);

        // Reset during the strobe of a read.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_word = 1'b0;
        req_address = 4'h2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (ior_n && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_strobe_reached", 32'(ior_n), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_ior_n", 32'(ior_n), 32'd1);
        check("rst_iow_n", 32'(iow_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        nrsp = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        check("rst_no_rsp", 32'(nrsp), 32'd0);

        // Randomized traffic, including back-to-back requests and sporadic resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            req_valid = (c >= 2000 && c < 2600) ? 1'b1 : ($urandom_range(0, 2) != 0);
            req_write = 1'($urandom);
            req_word = 1'($urandom);
            req_address = 4'($urandom);
            req_data = 16'($urandom);
            bus_hold = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        bus_hold = 1'b0;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
